// File: rtl/read_master_pkg.sv
// Shared defaults for the read master and its FIFO.
// Holds the default bus geometry so the top and any wrapper agree on one set of numbers.
package read_master_pkg;

  localparam int unsigned DefDataWidth     = 32;
  localparam int unsigned DefByteEnWidth   = DefDataWidth / 8;
  localparam int unsigned DefAddrWidth     = 32;
  localparam int unsigned DefFifoDepth     = 32;
  localparam int unsigned DefFifoDepthLog2 = 5;

endpackage

// File: rtl/read_master_fifo.sv
// Show-ahead synchronous FIFO buffering returned read data.
// Ports:
//   clk, reset_n  - clock and asynchronous active-low reset
//   push_i/data_i - write a word (ignored when full)
//   pop_i         - drop the head word (ignored when empty)
//   q_o           - head word, valid whenever empty_o is low
//   empty_o       - no words stored
//   used_o        - number of stored words, 0..Depth
module read_master_fifo #(
  parameter int unsigned Width     = 32,
  parameter int unsigned Depth     = 32,
  parameter int unsigned DepthLog2 = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push_i,
  input  logic [Width-1:0]     data_i,
  input  logic                 pop_i,
  output logic [Width-1:0]     q_o,
  output logic                 empty_o,
  output logic [DepthLog2:0]   used_o
);

  localparam logic [DepthLog2:0] Full = (DepthLog2 + 1)'(Depth);

  logic [Width-1:0]     mem_q [Depth];
  logic [DepthLog2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DepthLog2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DepthLog2:0]   used_q, used_d;
  logic                 do_push, do_pop;

  assign do_push = push_i & (used_q != Full);
  assign do_pop  = pop_i & (used_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    used_d   = used_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      used_d = used_q + 1'b1;
    else if (!do_push && do_pop) used_d = used_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
    end
  end

  // Storage needs no reset: contents are only visible through used_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign q_o     = mem_q[rd_ptr_q];
  assign empty_o = (used_q == '0);
  assign used_o  = used_q;

endmodule

// File: rtl/read_master.sv
// Avalon-MM pipelined read master feeding a show-ahead FIFO.
// Ports:
//   clk, reset_n               - clock and asynchronous active-low reset
//   control_*                  - base/length/fixed setup, go pulse, done status
//   user_read_buffer           - pop request for the head FIFO word
//   user_buffer_data           - head FIFO word
//   user_data_available        - FIFO not empty
//   master_*                   - Avalon-MM read master interface
// Reads are only posted while outstanding reads plus stored words leave room in the
// FIFO, so returning data can never overflow it.
module read_master
  import read_master_pkg::*;
#(
  parameter int unsigned DATAWIDTH       = DefDataWidth,
  parameter int unsigned BYTEENABLEWIDTH = DefByteEnWidth,
  parameter int unsigned ADDRESSWIDTH    = DefAddrWidth,
  parameter int unsigned FIFODEPTH       = DefFifoDepth,
  parameter int unsigned FIFODEPTH_LOG2  = DefFifoDepthLog2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0]    control_read_base,
  input  logic [ADDRESSWIDTH-1:0]    control_read_length,
  input  logic                       control_go,
  output logic                       control_done,
  input  logic                       user_read_buffer,
  output logic [DATAWIDTH-1:0]       user_buffer_data,
  output logic                       user_data_available,
  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_read,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  input  logic [DATAWIDTH-1:0]       master_readdata,
  input  logic                       master_waitrequest,
  input  logic                       master_readdatavalid
);

  localparam int unsigned CntW = FIFODEPTH_LOG2 + 1;
  localparam logic [BYTEENABLEWIDTH-1:0] ByteEnAll = '1;
  localparam logic [ADDRESSWIDTH-1:0]    WordBytes = ADDRESSWIDTH'(BYTEENABLEWIDTH);
  localparam logic [CntW:0]              DepthCnt  = (CntW + 1)'(FIFODEPTH);

  logic [ADDRESSWIDTH-1:0] address_q, address_d;
  logic [ADDRESSWIDTH-1:0] length_q, length_d;
  logic [CntW-1:0]         pending_q, pending_d;
  logic                    fixed_q, fixed_d;

  logic [CntW-1:0] fifo_used;
  logic            fifo_empty;
  logic [CntW:0]   reserved;
  logic            go_accept, read_accept, rdv_accept;

  // Words already committed to the FIFO: stored plus still in flight.
  assign reserved    = {1'b0, pending_q} + {1'b0, fifo_used};
  assign master_read = (length_q != '0) && (reserved < DepthCnt);
  assign read_accept = master_read & ~master_waitrequest;
  // Data with nothing outstanding belongs to reads issued before a reset; drop it.
  assign rdv_accept  = master_readdatavalid & (pending_q != '0);

  assign control_done = (length_q == '0) && (pending_q == '0);
  assign go_accept    = control_go & control_done;

  always_comb begin
    address_d = address_q;
    length_d  = length_q;
    fixed_d   = fixed_q;
    pending_d = pending_q;
    if (go_accept) begin
      address_d = control_read_base;
      length_d  = control_read_length;
      fixed_d   = control_fixed_location;
    end else if (read_accept) begin
      if (!fixed_q) address_d = address_q + WordBytes;
      // Saturate so a partial final word still costs one full read.
      length_d = (length_q > WordBytes) ? (length_q - WordBytes) : '0;
    end
    if (read_accept && !rdv_accept)      pending_d = pending_q + 1'b1;
    else if (!read_accept && rdv_accept) pending_d = pending_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address_q <= '0;
      length_q  <= '0;
      pending_q <= '0;
      fixed_q   <= 1'b0;
    end else begin
      address_q <= address_d;
      length_q  <= length_d;
      pending_q <= pending_d;
      fixed_q   <= fixed_d;
    end
  end

  read_master_fifo #(
    .Width     (DATAWIDTH),
    .Depth     (FIFODEPTH),
    .DepthLog2 (FIFODEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (rdv_accept),
    .data_i  (master_readdata),
    .pop_i   (user_read_buffer),
    .q_o     (user_buffer_data),
    .empty_o (fifo_empty),
    .used_o  (fifo_used)
  );

  assign user_data_available = ~fifo_empty;
  assign master_address      = address_q;
  assign master_byteenable   = ByteEnAll;

endmodule

// File: tb/tb_read_master.sv
module tb_read_master;

  localparam int unsigned FD = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        control_fixed_location;
  logic [31:0] control_read_base;
  logic [31:0] control_read_length;
  logic        control_go;
  logic        control_done;
  logic        user_read_buffer;
  logic [31:0] user_buffer_data;
  logic        user_data_available;
  logic [31:0] master_address;
  logic        master_read;
  logic [3:0]  master_byteenable;
  logic [31:0] master_readdata;
  logic        master_waitrequest;
  logic        master_readdatavalid;

  always #5 clk = ~clk;

  read_master dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .control_fixed_location (control_fixed_location),
    .control_read_base      (control_read_base),
    .control_read_length    (control_read_length),
    .control_go             (control_go),
    .control_done           (control_done),
    .user_read_buffer       (user_read_buffer),
    .user_buffer_data       (user_buffer_data),
    .user_data_available    (user_data_available),
    .master_address         (master_address),
    .master_read            (master_read),
    .master_byteenable      (master_byteenable),
    .master_readdata        (master_readdata),
    .master_waitrequest     (master_waitrequest),
    .master_readdatavalid   (master_readdatavalid)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h, required no such event", name, act);
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] addr, input int idx);
    logic [7:0] tag;
    tag = idx[7:0];
    return {tag, 8'h5A, addr[15:0]};
  endfunction

  // Scoreboard queues filled by stimulus, drained by the monitor.
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;
  rsp_t rsp_q[$];

  int   cyc        = 0;
  int   lat        = 2;
  int   slave_idx  = 0;
  int   reads_seen = 0;
  logic stray_rdv  = 1'b0;
  logic check_occ  = 1'b0;

  // Monitor plus slave memory model; everything happens on the falling edge.
  always @(negedge clk) begin
    rsp_t r;
    cyc++;
    if (!reset_n) begin
      rsp_q.delete();
      exp_addr_q.delete();
      exp_data_q.delete();
      master_readdatavalid = 1'b0;
      master_readdata      = '0;
    end else begin
      if (user_read_buffer && user_data_available) begin
        if (exp_data_q.size() == 0) fail_evt("unexpected_pop", user_buffer_data);
        else check("fifo_data", user_buffer_data, exp_data_q.pop_front());
      end
      if (master_read && !master_waitrequest) begin
        reads_seen++;
        if (exp_addr_q.size() == 0) fail_evt("unexpected_read", master_address);
        else check("read_addr", master_address, exp_addr_q.pop_front());
        check("byteenable", {28'h0, master_byteenable}, 32'hF);
        rsp_q.push_back('{due: cyc + lat, data: data_of(master_address, slave_idx)});
        slave_idx++;
      end
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        r = rsp_q.pop_front();
        master_readdatavalid = 1'b1;
        master_readdata      = r.data;
      end else if (stray_rdv) begin
        master_readdatavalid = 1'b1;
        master_readdata      = 32'hBAD0_0001;
      end else begin
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
      end
      if (master_readdatavalid && dut.u_fifo.used_o == 6'(FD))
        fail_evt("rdv_while_full", {26'h0, dut.u_fifo.used_o});
      if (check_occ)
        check("occupancy_le_depth",
              32'(({26'h0, dut.pending_q} + {26'h0, dut.u_fifo.used_o}) <= FD), 32'h1);
    end
  end

  task automatic expect_xfer(input logic [31:0] base, input int nwords, input logic fixed);
    logic [31:0] a;
    slave_idx = 0;
    for (int i = 0; i < nwords; i++) begin
      a = fixed ? base : base + 32'(4 * i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(data_of(a, i));
    end
  endtask

  task automatic go(input logic [31:0] base, input logic [31:0] len, input logic fixed);
    @(posedge clk); #1;
    control_read_base      = base;
    control_read_length    = len;
    control_fixed_location = fixed;
    control_go             = 1'b1;
    @(posedge clk); #1;
    control_go = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (control_done && !user_data_available &&
          exp_data_q.size() == 0 && exp_addr_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, {31'h0, ok}, 32'h1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    int n;
    reset_n                = 1'b0;
    control_fixed_location = 1'b0;
    control_read_base      = '0;
    control_read_length    = '0;
    control_go             = 1'b0;
    user_read_buffer       = 1'b0;
    master_waitrequest     = 1'b0;
    #2;
    check("rst_master_read", {31'h0, master_read}, 32'h0);
    check("rst_done", {31'h0, control_done}, 32'h1);
    check("rst_avail", {31'h0, user_data_available}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Basic transfer: 4 reads, latency 2, popping every cycle.
    lat = 2;
    user_read_buffer = 1'b1;
    r0 = reads_seen;
    expect_xfer(32'h100, 4, 1'b0);
    go(32'h100, 32'd16, 1'b0);
    check("basic_busy", {31'h0, control_done}, 32'h0);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (control_done) begin
        n = i;
        break;
      end
    end
    check("basic_done_latency", n, 7);
    wait_idle("basic_idle", 20);
    check("basic_reads", reads_seen - r0, 4);

    // Backpressure: no pops, so only FIFODEPTH reads may be outstanding or stored.
    user_read_buffer = 1'b0;
    check_occ = 1'b1;
    r0 = reads_seen;
    expect_xfer(32'h1000, 64, 1'b0);
    go(32'h1000, 32'd256, 1'b0);
    repeat (60) @(negedge clk);
    check("bp_reads_full", reads_seen - r0, 32);
    check("bp_read_low", {31'h0, master_read}, 32'h0);
    @(posedge clk); #1 user_read_buffer = 1'b1;
    @(posedge clk); #1 user_read_buffer = 1'b0;
    repeat (10) @(negedge clk);
    check("bp_reads_one_more", reads_seen - r0, 33);
    check("bp_read_low_again", {31'h0, master_read}, 32'h0);
    user_read_buffer = 1'b1;
    wait_idle("bp_idle", 300);
    check("bp_reads_total", reads_seen - r0, 64);
    check_occ = 1'b0;

    // Waitrequest stall on the second read.
    r0 = reads_seen;
    expect_xfer(32'h200, 3, 1'b0);
    go(32'h200, 32'd12, 1'b0);
    @(posedge clk); #1 master_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("wr_addr_hold", master_address, 32'h204);
      check("wr_read_hold", {31'h0, master_read}, 32'h1);
      check("wr_len_hold", dut.length_q, 32'd8);
      @(posedge clk); #1;
    end
    master_waitrequest = 1'b0;
    wait_idle("wr_idle", 30);
    check("wr_reads", reads_seen - r0, 3);

    // Fixed location with a length that is not a word multiple.
    r0 = reads_seen;
    expect_xfer(32'h40, 3, 1'b1);
    go(32'h40, 32'd10, 1'b1);
    wait_idle("fixed_idle", 30);
    check("fixed_reads", reads_seen - r0, 3);
    check("fixed_done", {31'h0, control_done}, 32'h1);

    // Go while busy must be ignored.
    lat = 4;
    r0 = reads_seen;
    expect_xfer(32'h300, 8, 1'b0);
    go(32'h300, 32'd32, 1'b0);
    @(posedge clk); #1;
    control_read_base   = 32'h800;
    control_read_length = 32'd4;
    control_go          = 1'b1;
    @(posedge clk); #1 control_go = 1'b0;
    wait_idle("busy_go_idle", 50);
    check("busy_go_reads", reads_seen - r0, 8);

    // Zero length go.
    lat = 2;
    r0 = reads_seen;
    go(32'h500, 32'd0, 1'b0);
    check("len0_done", {31'h0, control_done}, 32'h1);
    repeat (10) @(negedge clk);
    check("len0_reads", reads_seen - r0, 0);
    check("len0_done_later", {31'h0, control_done}, 32'h1);

    // Reset with three reads outstanding, then stray returned data.
    lat = 20;
    user_read_buffer = 1'b0;
    expect_xfer(32'h600, 16, 1'b0);
    go(32'h600, 32'd64, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pending_pre", {26'h0, dut.pending_q}, 32'd3);
    reset_n = 1'b0;
    #1;
    check("midrst_master_read", {31'h0, master_read}, 32'h0);
    check("midrst_done", {31'h0, control_done}, 32'h1);
    check("midrst_avail", {31'h0, user_data_available}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    lat = 2;
    stray_rdv = 1'b1;
    repeat (3) @(posedge clk);
    #1 stray_rdv = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_avail", {31'h0, user_data_available}, 32'h0);
    check("stray_done", {31'h0, control_done}, 32'h1);
    check("stray_read", {31'h0, master_read}, 32'h0);

    check("end_addr_q_empty", exp_addr_q.size(), 0);
    check("end_data_q_empty", exp_data_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
